sm_seven_seg_reader: RTL and testbench
======================================

// Module: sm_seven_seg_reader
// PURPOSE
//  Reader end of the multiplexed seven-segment display bus: samples anode strobes and
//  active-low segment patterns (bit order g f e d c b a), waits for each pattern to
//  settle, then decodes it back to a hex nibble. Produces a packed number plus
//  per-digit validity, and pulses once per completed scan frame. Used for board
//  self-test and loopback checking of the display driver path.
// PARAMETERS
//  DIGITS         8    number of multiplexed digits (anode lines), >= 1
//  STABLE_CYCLES  4    consecutive identical samples required before capture, >= 2
// PORTS
//  clk          in   1           system clock, all logic on rising edge
//  rst_n        in   1           synchronous active-low reset
//  anodes       in   DIGITS      digit select, active-low, legal when exactly one bit is 0
//  segments     in   7           segment pattern, active-low, {g,f,e,d,c,b,a}
//  number       out  4*DIGITS    decoded nibbles; digit i at [4*i+3:4*i]
//  digit_valid  out  DIGITS      1 = slot i holds a valid hex decode
//  frame_valid  out  1           one-cycle pulse: every digit captured since last pulse
//  bad_pattern  out  1           one-cycle pulse: settled pattern matches no hex glyph/blank
//  bad_digit    out  $clog2(DIGITS) (min 1)  index of digit that raised bad_pattern
// BEHAVIOUR
//  Reset (rst_n=0 at edge): number=0, digit_valid=0, frame_valid=0, bad_pattern=0,
//   bad_digit=0; sample regs all 1s, stability counter=0, captured flag=0, seen mask=0.
//   Reset mid-window abandons the partial window; no capture is made.
//  Input stage: {anodes,segments} registered once (sample S). Legal = exactly one 0 in S.anodes.
//  Stability: counter increments (saturating at STABLE_CYCLES) while S is legal and equal
//   to previous S; any change or illegal S -> counter=0, captured=0.
//  Capture: when counter reaches STABLE_CYCLES-1 and captured=0 -> one capture, captured=1;
//   no further capture until S changes. Latency: inputs held steady from edge E ->
//   outputs update at edge E+STABLE_CYCLES.
//  Decode (exact match, 16 glyphs): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//   5=0010010 6=0000010 7=1111000 8=0000000 9=0011000 A=0001000 b=0000011 C=1000110
//   d=0100001 E=0000110 F=0001110; blank=1111111.
//  On capture of digit i: match -> nibble i written, digit_valid[i]=1.
//   blank -> digit_valid[i]=0, nibble i unchanged, no error.
//   other -> digit_valid[i]=0, nibble unchanged, bad_pattern=1, bad_digit=i (same edge).
//   In all three cases seen[i]=1.
//  Frame: if the capture sets the last 0 bit of seen -> frame_valid=1 on that same edge
//   and seen cleared to 0. Re-capturing an already-seen digit just overwrites; no frame.
//  All anodes high (blanking interval) or >1 low: no capture, seen mask held.
//  frame_valid and bad_pattern are 0 on every cycle without the above events.
// STRUCTURE
//  Package sm_display_pkg: SEG_W=7, seg_t typedef (logic [6:0]), localparams SEG_0..SEG_F,
//   SEG_BLANK; shared with the hex-to-segment encoder so both ends use one glyph table.
//  Sub-module sm_seg_to_hex (combinational): seg_t in -> {hit, blank, nibble[3:0]}.
//  Top holds sample regs, stability counter, one-hot-to-index encoder, seen mask, outputs.
// TESTING
//  1 Reset: drive rst_n=0 two cycles with random inputs -> all outputs 0, no pulses.
//  2 DIGITS=8, STABLE=4: scan digits 0..7 with glyphs 1,2,3,4,5,6,7,8, each held 6 cycles
//    -> number=32'h87654321, digit_valid=8'hFF, exactly one frame_valid on digit 7 capture.
//  3 Digit 2 held only 3 cycles -> no capture, number[11:8] unchanged, seen[2] stays 0.
//  4 Digit 5 shows 1010101 held 4 cycles -> bad_pattern pulse, bad_digit=5, digit_valid[5]=0.
//  5 anodes=8'b11110011 or 8'hFF held 10 cycles -> no capture, no pulses, counter stays 0.
//  6 Digit 0 shows 'b' for 4 cycles, then rst_n=0 at the capture edge -> outputs reset, no capture.

Source files
------------

// File: rtl/sm_display_pkg.sv
// Glyph table shared by the seven-segment encoder and the reader, so both ends of the
// display bus agree on every pattern. Patterns are active-low, bit order {g,f,e,d,c,b,a}.
package sm_display_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0011000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;

  // Encoder direction, used by the driver side of the display path.
  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    seg_t seg;
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sm_seg_to_hex.sv
// Exact-match decoder from an active-low segment pattern back to a hex nibble.
// hit_o marks one of the 16 glyphs; blank_o marks the all-off pattern.
module sm_seg_to_hex
  import sm_display_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output logic             hit_o,
  output logic             blank_o,
  output logic [3:0]       nibble_o
);

  // NOTE: every output gets a default before the case, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    hit_o    = 1'b1;
    blank_o  = 1'b0;
    nibble_o = 4'h0;
    case (seg_i)
      SEG_0: nibble_o = 4'h0;
      SEG_1: nibble_o = 4'h1;
      SEG_2: nibble_o = 4'h2;
      SEG_3: nibble_o = 4'h3;
      SEG_4: nibble_o = 4'h4;
      SEG_5: nibble_o = 4'h5;
      SEG_6: nibble_o = 4'h6;
      SEG_7: nibble_o = 4'h7;
      SEG_8: nibble_o = 4'h8;
      SEG_9: nibble_o = 4'h9;
      SEG_A: nibble_o = 4'hA;
      SEG_B: nibble_o = 4'hB;
      SEG_C: nibble_o = 4'hC;
      SEG_D: nibble_o = 4'hD;
      SEG_E: nibble_o = 4'hE;
      SEG_F: nibble_o = 4'hF;
      SEG_BLANK: begin
        hit_o   = 1'b0;
        blank_o = 1'b1;
      end
      default: hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/sm_seven_seg_reader.sv
// Reader end of the multiplexed seven-segment bus: waits for each anode/segment pair to
// settle, decodes it to a nibble, and reports per-digit validity and completed frames.
module sm_seven_seg_reader
  import sm_display_pkg::*;
#(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4,
  localparam int IDX_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     anodes,
  input  logic [SEG_W-1:0]      segments,
  output logic [4*DIGITS-1:0]   number,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_valid,
  output logic                  bad_pattern,
  output logic [IDX_W-1:0]      bad_digit
);

  localparam int ZC_W  = $clog2(DIGITS + 1);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [DIGITS-1:0]   s_anodes_q, p_anodes_q;
  logic [SEG_W-1:0]    s_seg_q, p_seg_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                captured_q, captured_d;
  logic [DIGITS-1:0]   seen_q, seen_d, seen_set;
  logic [4*DIGITS-1:0] number_q, number_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic                frame_q, frame_d;
  logic                bad_q, bad_d;
  logic [IDX_W-1:0]    bad_digit_q, bad_digit_d;

  logic [ZC_W-1:0]     zero_cnt;
  logic [IDX_W-1:0]    digit_idx;
  logic                legal, same, capture;
  logic                dec_hit, dec_blank;
  logic [3:0]          dec_nibble;

  // Count active (low) anodes and remember the position of the last one found; the
  // position is only used when exactly one is active.
  always_comb begin
    zero_cnt  = '0;
    digit_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!s_anodes_q[i]) begin
        zero_cnt  = zero_cnt + ZC_W'(1);
        digit_idx = IDX_W'(i);
      end
    end
  end

  assign legal = (zero_cnt == ZC_W'(1));
  assign same  = (s_anodes_q == p_anodes_q) && (s_seg_q == p_seg_q);

  always_comb begin
    cnt_d      = cnt_q;
    captured_d = captured_q;
    capture    = 1'b0;
    if (!legal || !same) begin
      cnt_d      = '0;
      captured_d = 1'b0;
    end else begin
      if (cnt_q != CNT_W'(STABLE_CYCLES)) cnt_d = cnt_q + CNT_W'(1);
      if ((cnt_d == CNT_W'(STABLE_CYCLES - 1)) && !captured_q) begin
        capture    = 1'b1;
        captured_d = 1'b1;
      end
    end
  end

  sm_seg_to_hex u_seg_to_hex (
    .seg_i    (s_seg_q),
    .hit_o    (dec_hit),
    .blank_o  (dec_blank),
    .nibble_o (dec_nibble)
  );

  always_comb begin
    number_d    = number_q;
    valid_d     = valid_q;
    seen_d      = seen_q;
    bad_digit_d = bad_digit_q;
    frame_d     = 1'b0;
    bad_d       = 1'b0;
    seen_set    = seen_q | ~s_anodes_q;
    if (capture) begin
      if (dec_hit) begin
        number_d[4*digit_idx +: 4] = dec_nibble;
        valid_d[digit_idx]         = 1'b1;
      end else begin
        valid_d[digit_idx] = 1'b0;
        if (!dec_blank) begin
          bad_d       = 1'b1;
          bad_digit_d = digit_idx;
        end
      end
      // A frame closes only when this capture fills the last empty slot.
      if (&seen_set) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d = seen_set;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples the
  // pre-edge value of its source, which makes the S -> previous-S shift work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_anodes_q  <= '1;
      s_seg_q     <= '1;
      p_anodes_q  <= '1;
      p_seg_q     <= '1;
      cnt_q       <= '0;
      captured_q  <= 1'b0;
      seen_q      <= '0;
      number_q    <= '0;
      valid_q     <= '0;
      frame_q     <= 1'b0;
      bad_q       <= 1'b0;
      bad_digit_q <= '0;
    end else begin
      s_anodes_q  <= anodes;
      s_seg_q     <= segments;
      p_anodes_q  <= s_anodes_q;
      p_seg_q     <= s_seg_q;
      cnt_q       <= cnt_d;
      captured_q  <= captured_d;
      seen_q      <= seen_d;
      number_q    <= number_d;
      valid_q     <= valid_d;
      frame_q     <= frame_d;
      bad_q       <= bad_d;
      bad_digit_q <= bad_digit_d;
    end
  end

  assign number      = number_q;
  assign digit_valid = valid_q;
  assign frame_valid = frame_q;
  assign bad_pattern = bad_q;
  assign bad_digit   = bad_digit_q;

endmodule

// File: tb/tb_sm_seven_seg_reader.sv
// Scoreboard bench: a hold-level model predicts each capture and its cycle; a monitor
// compares DUT outputs against due predictions and against the quiet state otherwise.
module tb_sm_seven_seg_reader;

  localparam int D  = 8;
  localparam int ST = 4;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [D-1:0]    anodes;
  logic [6:0]      segments;
  logic [4*D-1:0]  number;
  logic [D-1:0]    digit_valid;
  logic            frame_valid;
  logic            bad_pattern;
  logic [IW-1:0]   bad_digit;

  sm_seven_seg_reader #(.DIGITS(D), .STABLE_CYCLES(ST)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .anodes      (anodes),
    .segments    (segments),
    .number      (number),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .bad_pattern (bad_pattern),
    .bad_digit   (bad_digit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             cyc;
    logic [4*D-1:0] num;
    logic [D-1:0]   val;
    logic           frame;
    logic           bad;
    logic [IW-1:0]  bd;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic [3:0]    m_num [D];
  logic [D-1:0]  m_val, m_seen;
  logic [IW-1:0] m_bd;
  logic [D+6:0]  last_drv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  function automatic logic [4*D-1:0] pack_num();
    logic [4*D-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++) r[4*i +: 4] = m_num[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_num[i] = 4'h0;
    m_val  = '0;
    m_seen = '0;
    m_bd   = '0;
  endtask

  // A legal pattern held for at least ST sampled edges is captured exactly once,
  // ST edges after the first edge that sampled it.
  task automatic model_hold(input logic [D-1:0] a, input logic [6:0] s, input int n);
    int   zeros, idx, k;
    exp_t e;
    zeros = 0; idx = 0; k = -1;
    if (n < ST) return;
    for (int i = 0; i < D; i++) if (a[i] == 1'b0) begin zeros++; idx = i; end
    if (zeros != 1) return;
    for (int g = 0; g < 16; g++) if (glyph[g] == s) k = g;
    e.frame = 1'b0;
    e.bad   = 1'b0;
    if (k >= 0) begin
      m_num[idx] = k[3:0];
      m_val[idx] = 1'b1;
    end else begin
      m_val[idx] = 1'b0;
      if (s != 7'h7F) begin
        e.bad = 1'b1;
        m_bd  = idx[IW-1:0];
      end
    end
    m_seen[idx] = 1'b1;
    if (m_seen == {D{1'b1}}) begin
      e.frame = 1'b1;
      m_seen  = '0;
    end
    e.cyc = cyc + 1 + ST;
    e.num = pack_num();
    e.val = m_val;
    e.bd  = m_bd;
    sb.push_back(e);
  endtask

  task automatic hold(input logic [D-1:0] a, input logic [6:0] s, input int n);
    model_hold(a, s, n);
    anodes   = a;
    segments = s;
    last_drv = {a, s};
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_digit(input int d, input logic [6:0] s, input int n);
    logic [D-1:0] a;
    a = ~(D'(1) << d);
    hold(a, s, n);
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    while (sb.size() > 0 && sb[sb.size()-1].cyc >= cyc + 1) e = sb.pop_back();
    for (int k = 1; k <= n; k++) begin
      e.cyc = cyc + k; e.num = '0; e.val = '0; e.frame = 1'b0; e.bad = 1'b0; e.bd = '0;
      sb.push_back(e);
    end
    model_reset();
    rst_n = 1'b0;
    repeat (n) begin
      anodes   = D'($urandom);
      segments = 7'($urandom);
      @(negedge clk);
    end
    rst_n    = 1'b1;
    last_drv = '1;
  endtask

  exp_t           mon_e;
  logic [4*D-1:0] q_num;
  logic [D-1:0]   q_val;
  logic [IW-1:0]  q_bd;

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        mon_e = sb.pop_front();
        check("number",      64'(number),      64'(mon_e.num));
        check("digit_valid", 64'(digit_valid), 64'(mon_e.val));
        check("frame_valid", 64'(frame_valid), 64'(mon_e.frame));
        check("bad_pattern", 64'(bad_pattern), 64'(mon_e.bad));
        check("bad_digit",   64'(bad_digit),   64'(mon_e.bd));
        q_num = mon_e.num;
        q_val = mon_e.val;
        q_bd  = mon_e.bd;
      end else begin
        check("quiet", 64'({frame_valid, bad_pattern, digit_valid, number, bad_digit}),
              64'({1'b0, 1'b0, q_val, q_num, q_bd}));
      end
    end
  end

  initial begin
    logic [D-1:0] a;
    logic [6:0]   s;
    int           r, n;

    anodes   = '1;
    segments = '1;
    do_reset(2);

    for (int i = 0; i < D; i++) hold_digit(i, glyph[i+1], 6);
    check("scan_number", 64'(number), 64'h87654321);
    check("scan_valid",  64'(digit_valid), 64'hFF);

    hold_digit(2, glyph[9], 3);
    for (int i = 0; i < D; i++) if (i != 2) hold_digit(i, glyph[15-i], 6);
    hold_digit(2, glyph[10], 6);

    hold_digit(5, 7'b1010101, 4);
    hold(8'b11110011, glyph[3], 10);
    hold(8'hFF, glyph[4], 10);

    hold_digit(0, glyph[11], 4);
    do_reset(2);

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 24) == 0) begin
        do_reset($urandom_range(1, 2));
        continue;
      end
      do begin
        r = $urandom_range(0, 9);
        a = ~(D'(1) << $urandom_range(0, D-1));
        if (r <= 6)      s = glyph[$urandom_range(0, 15)];
        else if (r == 7) s = 7'h7F;
        else             s = 7'($urandom);
        if (r == 9) a = D'($urandom);
      end while ({a, s} == last_drv);
      n = $urandom_range(1, 7);
      hold(a, s, n);
    end

    hold(8'hFF, 7'h7F, ST + 4);
    check("drain", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
